// File: rtl/scope_capture_pkg.sv
// scope_pkg: shared sample width, sweep length and capture FSM state type
// Used by scope_capture and the future register decoder.
package scope_pkg;
    localparam int SAMPLE_W = 12;
    localparam int H_PIXELS = 640;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } cap_state_t;
endpackage

// File: rtl/scope_capture_if.sv
// scope_capture_if: ADC sample stream, frame sync and renderer read port
// master: sample source / renderer side; slave: scope_capture.
interface scope_capture_if #(
    parameter int SAMPLE_W = 12,
    parameter int ADDR_W   = 10
);
    logic                sample_valid;
    logic [SAMPLE_W-1:0] sample_data;
    logic                frame_start;
    logic [ADDR_W-1:0]   rd_addr;
    logic [SAMPLE_W-1:0] rd_data;
    modport master (output sample_valid, sample_data, frame_start, rd_addr, input rd_data);
    modport slave (input sample_valid, sample_data, frame_start, rd_addr, output rd_data);
endinterface

// File: rtl/scope_capture_ram.sv
// scope_capture_ram: 2*DEPTH x SAMPLE_W simple dual-port RAM, one write port, registered read
// Ports: clk, reset (async active-low, clears only the read register), we/wbank/widx/wdata,
// rbank/ridx -> rdata (1-cycle latency). Entry address is bank*DEPTH + index.
module scope_capture_ram #(
    parameter int SAMPLE_W = 12,
    parameter int DEPTH    = 640,
    parameter int ADDR_W   = 10
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                wbank,
    input  logic [ADDR_W-1:0]   widx,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                rbank,
    input  logic [ADDR_W-1:0]   ridx,
    output logic [SAMPLE_W-1:0] rdata
);
    localparam logic [ADDR_W:0] DEP = (ADDR_W + 1)'(DEPTH);
    logic [SAMPLE_W-1:0] mem [0:2*DEPTH-1];
    logic [ADDR_W:0] wa, ra;
    assign wa = wbank ? DEP + {1'b0, widx} : {1'b0, widx};
    assign ra = rbank ? DEP + {1'b0, ridx} : {1'b0, ridx};
    always_ff @(posedge clk)
        if (we) mem[wa] <= wdata;
    always_ff @(posedge clk or negedge reset)
        if (!reset) rdata <= '0;
        else rdata <= mem[ra];
endmodule

// File: rtl/scope_capture.sv
// scope_capture: trigger detect and decimated sweep capture into a ping-pong buffer
// Ports: clk, reset (async active-low), bus (sample stream, frame_start, rd_addr/rd_data),
// run, auto_mode, trig_level, trig_falling, decim (config); state, disp_bank, swapped (status).
module scope_capture #(
    parameter int SAMPLE_W = scope_pkg::SAMPLE_W,
    parameter int DEPTH    = scope_pkg::H_PIXELS,
    parameter int ADDR_W   = 10,
    parameter int AUTO_TO  = 65535
) (
    input  logic                clk,
    input  logic                reset,
    scope_capture_if.slave      bus,
    input  logic                run,
    input  logic                auto_mode,
    input  logic [SAMPLE_W-1:0] trig_level,
    input  logic                trig_falling,
    input  logic [7:0]          decim,
    output logic [1:0]          state,
    output logic                disp_bank,
    output logic                swapped
);
    import scope_pkg::*;
    localparam int AW = $clog2(AUTO_TO + 1);
    cap_state_t          st;
    logic [SAMPLE_W-1:0] prev;
    logic                prev_ok;
    logic [AW-1:0]       auto_cnt;
    logic [ADDR_W-1:0]   wr_idx;
    logic [7:0]          dec_cnt, dec_r;
    logic                vld, edge_hit, trig, cap_wr;
    assign vld      = bus.sample_valid && run;
    assign edge_hit = trig_falling ? (prev >= trig_level && bus.sample_data < trig_level)
                                   : (prev < trig_level && bus.sample_data >= trig_level);
    assign trig     = st == ARMED && vld &&
                      ((prev_ok && edge_hit) || (auto_mode && auto_cnt == AW'(AUTO_TO - 1)));
    assign cap_wr   = st == CAPTURE && vld && dec_cnt == 8'd0;
    assign state    = st;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            st        <= IDLE;
            disp_bank <= 1'b0;
            swapped   <= 1'b0;
            prev      <= '0;
            prev_ok   <= 1'b0;
            auto_cnt  <= '0;
            wr_idx    <= '0;
            dec_cnt   <= '0;
            dec_r     <= '0;
        end else begin
            swapped <= 1'b0;
            case (st)
                IDLE: if (run) begin
                    st       <= ARMED;
                    prev_ok  <= 1'b0;
                    auto_cnt <= '0;
                end
                ARMED: if (!run) st <= IDLE;
                else if (trig) begin
                    st      <= CAPTURE;
                    wr_idx  <= ADDR_W'(1);
                    dec_cnt <= decim;
                    dec_r   <= decim;
                end else if (vld) begin
                    prev     <= bus.sample_data;
                    prev_ok  <= 1'b1;
                    auto_cnt <= auto_cnt + 1'b1;
                end
                CAPTURE: if (!run) st <= IDLE;
                else if (cap_wr) begin
                    wr_idx  <= wr_idx + 1'b1;
                    dec_cnt <= dec_r;
                    if (wr_idx == ADDR_W'(DEPTH - 1)) st <= DONE;
                end else if (vld) dec_cnt <= dec_cnt - 8'd1;
                DONE: if (bus.frame_start) begin
                    disp_bank <= ~disp_bank;
                    swapped   <= 1'b1;
                    st        <= run ? ARMED : IDLE;
                    prev_ok   <= 1'b0;
                    auto_cnt  <= '0;
                end
                default: st <= IDLE;
            endcase
        end
    end
    scope_capture_ram #(.SAMPLE_W(SAMPLE_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .reset (reset),
        .we    (trig || cap_wr),
        .wbank (~disp_bank),
        .widx  (trig ? '0 : wr_idx),
        .wdata (bus.sample_data),
        .rbank (disp_bank),
        .ridx  (bus.rd_addr),
        .rdata (bus.rd_data)
    );
endmodule

// File: tb/tb_scope_capture.sv
// tb_scope_capture: directed vector bench for scope_capture
module tb_scope_capture;
    localparam logic [1:0] S_IDLE = 2'd0, S_ARMED = 2'd1, S_CAP = 2'd2, S_DONE = 2'd3;
    logic clk = 1'b0, reset = 1'b0;
    logic run = 1'b0, auto_mode = 1'b0, trig_falling = 1'b0;
    logic [11:0] trig_level = 12'h800;
    logic [7:0] decim = 8'd0;
    logic [1:0] state;
    logic disp_bank, swapped;
    int total = 0, bad = 0;
    scope_capture_if #(.SAMPLE_W(12), .ADDR_W(10)) bus ();
    scope_capture #(.SAMPLE_W(12), .DEPTH(640), .ADDR_W(10), .AUTO_TO(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .run          (run),
        .auto_mode    (auto_mode),
        .trig_level   (trig_level),
        .trig_falling (trig_falling),
        .decim        (decim),
        .state        (state),
        .disp_bank    (disp_bank),
        .swapped      (swapped)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic [11:0] d;
        logic [1:0]  st;
    } vec_t;
    vec_t tv [5];
    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", n, act, exp, $time);
        end
    endtask
    task automatic step();
        @(posedge clk);
        #1;
    endtask
    task automatic send(input logic [11:0] d);
        bus.sample_valid = 1'b1;
        bus.sample_data  = d;
        step();
        bus.sample_valid = 1'b0;
    endtask
    task automatic rd(input int a, output logic [11:0] q);
        bus.rd_addr = 10'(a);
        step();
        q = bus.rd_data;
    endtask
    task automatic swap(input logic [1:0] exp_st, input logic exp_bank);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("swap_pulse", swapped, 1);
        chk("swap_bank", disp_bank, exp_bank);
        chk("swap_state", state, exp_st);
        step();
        chk("swap_pulse_end", swapped, 0);
    endtask
    logic [11:0] q;
    initial begin
        tv[0] = '{12'h900, S_ARMED};
        tv[1] = '{12'h7F0, S_ARMED};
        tv[2] = '{12'h7F8, S_ARMED};
        tv[3] = '{12'h800, S_CAP};
        tv[4] = '{12'h808, S_CAP};
        bus.sample_valid = 1'b0;
        bus.sample_data  = '0;
        bus.frame_start  = 1'b0;
        bus.rd_addr      = '0;
        #12;
        chk("rst_state", state, S_IDLE);
        chk("rst_bank", disp_bank, 0);
        chk("rst_swapped", swapped, 0);
        chk("rst_rd_data", bus.rd_data, 0);
        reset = 1'b1;
        run = 1'b1;
        step();
        chk("arm", state, S_ARMED);
        // rising trigger: first sample cannot trigger, 0x800 does
        for (int i = 0; i < 5; i++) begin
            send(tv[i].d);
            chk("tbl_state", state, tv[i].st);
        end
        for (int k = 2; k < 640; k++) begin
            send(12'((12'h800 + 8 * k) & 12'hFFF));
            if (k == 638) chk("rise_last_cap", state, S_CAP);
        end
        chk("rise_done", state, S_DONE);
        chk("rise_bank_held", disp_bank, 0);
        swap(S_ARMED, 1'b1);
        rd(0, q);   chk("rise_idx0", q, 12'h800);
        rd(1, q);   chk("rise_idx1", q, 12'h808);
        rd(2, q);   chk("rise_idx2", q, 12'h810);
        rd(639, q); chk("rise_idx639", q, (12'h800 + 8 * 639) & 12'hFFF);
        // falling trigger with decim=3
        trig_falling = 1'b1;
        decim = 8'd3;
        send(12'h810); chk("fall_pre0", state, S_ARMED);
        send(12'h808); chk("fall_pre1", state, S_ARMED);
        send(12'h800); chk("fall_pre2", state, S_ARMED);
        send(12'h7F8); chk("fall_trig", state, S_CAP);
        for (int j = 1; j <= 2556; j++) begin
            send(12'((2040 - j) & 12'hFFF));
            if (j == 1) decim = 8'd0;
            if (j == 2555) chk("fall_last_cap", state, S_CAP);
        end
        chk("fall_done", state, S_DONE);
        // read latency across swap, run ignored in DONE
        rd(5, q); chk("lat_pre", q, 12'h828);
        run = 1'b0;
        step();
        chk("done_ignores_run", state, S_DONE);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("lat_swap_old", bus.rd_data, 12'h828);
        chk("lat_swap_bank", disp_bank, 0);
        chk("lat_swap_pulse", swapped, 1);
        chk("lat_swap_idle", state, S_IDLE);
        step();
        chk("lat_new", bus.rd_data, 12'h7E4);
        rd(0, q);   chk("fall_idx0", q, 12'h7F8);
        rd(1, q);   chk("fall_idx1", q, 12'h7F4);
        rd(639, q); chk("fall_idx639", q, (2040 - 2556) & 12'hFFF);
        // frame_start outside DONE
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        chk("fs_idle_bank", disp_bank, 0);
        chk("fs_idle_pulse", swapped, 0);
        // auto trigger on 16th constant sample
        trig_falling = 1'b0;
        auto_mode = 1'b1;
        run = 1'b1;
        step();
        chk("auto_arm", state, S_ARMED);
        for (int i = 1; i <= 16; i++) begin
            send(12'h100);
            if (i == 15) chk("auto_15", state, S_ARMED);
        end
        chk("auto_16", state, S_CAP);
        for (int i = 1; i < 640; i++) send(12'h100);
        chk("auto_done", state, S_DONE);
        swap(S_ARMED, 1'b1);
        for (int i = 0; i < 640; i++) begin
            rd(i, q);
            chk("auto_data", q, 12'h100);
        end
        // abort mid-capture
        for (int i = 0; i < 26; i++) send(12'h200);
        chk("abort_cap", state, S_CAP);
        run = 1'b0;
        step();
        chk("abort_idle", state, S_IDLE);
        chk("abort_bank", disp_bank, 1);
        rd(3, q); chk("abort_hold", q, 12'h100);
        // async reset mid-capture
        run = 1'b1;
        step();
        for (int i = 0; i < 21; i++) send(12'h300);
        chk("rst2_cap", state, S_CAP);
        #3 reset = 1'b0;
        #1;
        chk("rst2_state", state, S_IDLE);
        chk("rst2_bank", disp_bank, 0);
        chk("rst2_rd", bus.rd_data, 0);
        auto_mode = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        chk("rst2_arm", state, S_ARMED);
        send(12'h900); chk("rst2_first", state, S_ARMED);
        send(12'h7F0); chk("rst2_second", state, S_ARMED);
        send(12'h900); chk("rst2_trig", state, S_CAP);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
